code_decoder_v: RTL and testbench
=================================

Name: code_decoder_v

Overview:
- Sequential counterpart of the 4-to-2 priority encoder. Accepts a stream of 2-bit codes on a valid/ready handshake and buffers them in a 2-entry FIFO.
- Decodes each code to a 4-bit one-hot word, delivered on a downstream valid/ready handshake.
- Keeps a sticky OR-accumulator of delivered words and a saturating delivery count, so downstream logic can rebuild the request vector the encoder compressed.

Parameters:
- CODE_W, 2, input code width.
- OUT_W, 4, decoded width; must equal 2**CODE_W.
- CNT_W, 8, delivery counter width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_code  in  CODE_W  code to decode.
- i_valid  in  1  i_code is valid this cycle.
- o_ready  out  1  block can accept a code this cycle.
- o_onehot  out  OUT_W  decoded word of the FIFO head.
- o_valid  out  1  o_onehot is valid.
- i_ready  in  1  downstream accepts o_onehot this cycle.
- i_clear  in  1  synchronous clear of o_accum and o_count.
- o_accum  out  OUT_W  OR of all words delivered since reset/clear.
- o_count  out  CNT_W  number of words delivered, saturating.

Behaviour:
- Reset (i_rst_n=0, asynchronous, any time): FIFO emptied, o_valid=0, o_ready=1, o_onehot=0, o_accum=0, o_count=0.
- Push occurs on a rising edge when i_valid && o_ready. i_code is ignored when i_valid=0.
- Pop occurs on a rising edge when o_valid && i_ready.
- FIFO:
  - 2 entries, registered storage; occupancy states EMPTY(0), ONE(1), FULL(2).
  - o_ready = (occupancy != FULL), derived from registers only.
  - o_valid = (occupancy != EMPTY).
- Latency: a code pushed into an EMPTY FIFO at edge N drives o_valid=1 with its decode after edge N. There is no combinational input-to-output path.
- Decode: o_onehot[k]=1 iff head code == k; o_onehot=0 whenever o_valid=0.
- Transitions:
  - EMPTY + push → ONE.
  - ONE + push only → FULL.
  - ONE + pop only → EMPTY.
  - ONE + push + pop → ONE, with the new head being the pushed code.
  - FULL + pop → ONE. Push is impossible in FULL because o_ready=0.
  - No transition for any other combination.
- Order: strictly FIFO; codes are never dropped or duplicated.
- o_onehot and o_valid hold stable while o_valid && !i_ready.
- Accumulator:
  - On a pop: o_accum <= o_accum | o_onehot; o_count <= o_count+1, saturating at 2**CNT_W-1 (255).
  - i_clear with no pop: o_accum <= 0, o_count <= 0.
  - i_clear with a simultaneous pop: o_accum <= popped word, o_count <= 1.
- Reset mid-transfer discards all buffered codes. No output is produced for them after reset release.

Optional Feature:
- Macro: CODE_DECODER_THERMO_EN.
- Defined: o_onehot carries a thermometer code instead, with bits [code:0] set (e.g. code 2 → 4'b0111). o_accum ORs thermometer words. Handshake, FIFO, latency and counter behaviour are unchanged.
- Undefined: one-hot decode as specified above.

Test Plan:
- Reset release, i_ready=1, push codes 0,1,2,3 on consecutive cycles → o_onehot 0001, 0010, 0100, 1000, each one cycle after its push; o_accum=1111, o_count=4.
- i_ready=0, push codes 3,1,2 → first two accepted, o_ready=0 after the 2nd push, 3rd held. Raise i_ready → outputs 1000 then 0010 then 0100, in order.
- FIFO at ONE (head=2), simultaneous push of 0 and pop → 0100 delivered, new o_onehot=0001, occupancy stays ONE.
- 300 deliveries of code 1 → o_count stops at 255, o_accum=0010. Then i_clear alone → o_count=0, o_accum=0. i_clear together with a pop of code 3 → o_count=1, o_accum=1000.
- FIFO FULL, assert i_rst_n=0 asynchronously mid-cycle → o_valid=0 and o_ready=1 immediately. After release, no stale output appears.
- With CODE_DECODER_THERMO_EN defined, push codes 0..3 → outputs 0001, 0011, 0111, 1111; o_accum=1111.

Source files
------------

// File: rtl/code_decoder_v.sv
// Streams 2-bit codes through a 2-entry FIFO and delivers their decoded word with a
// sticky OR-accumulator and saturating delivery count. Optional: CODE_DECODER_THERMO_EN.
module code_decoder_v #(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned OUT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [OUT_W-1:0]  o_onehot,
  output logic              o_valid,
  input  logic              i_ready,
  input  logic              i_clear,
  output logic [OUT_W-1:0]  o_accum,
  output logic [CNT_W-1:0]  o_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CODE_W-1:0]   r_head;
  logic [CODE_W-1:0]   r_tail;
  logic [CODE_W-1:0]   w_head_nxt;
  logic [CODE_W-1:0]   w_tail_nxt;
  logic                r_ready;
  logic                r_valid;
  logic [OUT_W-1:0]    r_onehot;
  logic [OUT_W-1:0]    w_word_nxt;
  logic [OUT_W-1:0]    r_accum;
  logic [CNT_W-1:0]    r_count;
  logic                w_push;
  logic                w_pop;

  function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] word;
    word = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
`ifdef CODE_DECODER_THERMO_EN
      word[k] = (k <= 32'(code));
`else
      word[k] = (k == 32'(code));
`endif
    end
    return word;
  endfunction

  assign w_push = i_valid && r_ready;
  assign w_pop  = r_valid && i_ready;

  // Occupancy FSM; the decoded head word is precomputed so all outputs come from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt = S_ONE;
          w_head_nxt  = i_code;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          w_head_nxt = i_code;
        end else if (w_push) begin
          w_state_nxt = S_FULL;
          w_tail_nxt  = i_code;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt = S_ONE;
          w_head_nxt  = r_tail;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    w_word_nxt = (w_state_nxt != S_EMPTY) ? decode(w_head_nxt) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_EMPTY;
      r_head   <= '0;
      r_tail   <= '0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
      r_onehot <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_head   <= w_head_nxt;
      r_tail   <= w_tail_nxt;
      r_ready  <= (w_state_nxt != S_FULL);
      r_valid  <= (w_state_nxt != S_EMPTY);
      r_onehot <= w_word_nxt;
    end
  end

  // A clear coinciding with a pop restarts the history from the popped word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_accum <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_accum <= w_pop ? r_onehot : '0;
      r_count <= w_pop ? CNT_W'(1) : '0;
    end else if (w_pop) begin
      r_accum <= r_accum | r_onehot;
      if (r_count != '1) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_ready  = r_ready;
  assign o_valid  = r_valid;
  assign o_onehot = r_onehot;
  assign o_accum  = r_accum;
  assign o_count  = r_count;

endmodule

// File: tb/tb_code_decoder_v.sv
// Scoreboard bench for code_decoder_v: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_code_decoder_v;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic [1:0] i_code = '0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [3:0] o_onehot;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic       i_clear = 1'b0;
  logic [3:0] o_accum;
  logic [7:0] o_count;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];
  int m_occ = 0;
  int m_accum = 0;
  int m_count = 0;

  code_decoder_v dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_valid(i_valid),
    .o_ready(o_ready), .o_onehot(o_onehot), .o_valid(o_valid), .i_ready(i_ready),
    .i_clear(i_clear), .o_accum(o_accum), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic int dec(input int code);
`ifdef CODE_DECODER_THERMO_EN
    return (1 << (code + 1)) - 1;
`else
    return 1 << code;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: compares DUT outputs to the model, then advances the model by this cycle's handshakes.
  always @(negedge i_clk) begin
    bit pop;
    bit push;
    int w;
    if (!i_rst_n) begin
      m_occ = 0;
      m_accum = 0;
      m_count = 0;
    end else begin
      w = (m_occ > 0 && exp_q.size() > 0) ? exp_q[0] : 0;
      chk("o_valid", 32'(o_valid), (m_occ > 0) ? 1 : 0);
      chk("o_ready", 32'(o_ready), (m_occ < 2) ? 1 : 0);
      chk("o_onehot", 32'(o_onehot), w);
      chk("o_accum", 32'(o_accum), m_accum);
      chk("o_count", 32'(o_count), m_count);
      pop  = (m_occ > 0) && i_ready;
      push = i_valid && (m_occ < 2);
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      if (i_clear) begin
        m_accum = pop ? w : 0;
        m_count = pop ? 1 : 0;
      end else if (pop) begin
        m_accum = m_accum | w;
        if (m_count < 255) m_count++;
      end
      m_occ = m_occ + int'(push) - int'(pop);
    end
  end

  // Drive one cycle; an accepted push enqueues its expected word.
  task automatic cyc(input bit v, input int c, input bit r, input bit clr, output bit acc);
    @(posedge i_clk);
    #1;
    i_valid = v;
    i_code  = 2'(c);
    i_ready = r;
    i_clear = clr;
    acc = v && o_ready;
    if (acc) exp_q.push_back(dec(c));
  endtask

  task automatic send(input int c, input bit r);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) cyc(1'b1, c, r, 1'b0, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int k = 0; k < n; k++) cyc(1'b0, 0, r, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_onehot", 32'(o_onehot), 0);
    chk("rst_accum", 32'(o_accum), 0);
    chk("rst_count", 32'(o_count), 0);
    i_rst_n = 1'b1;

    // Back-to-back codes with a ready sink.
    for (int c = 0; c < 4; c++) send(c, 1'b1);
    idle(3, 1'b1);
    chk("seq_accum", 32'(o_accum), 32'hf);
    chk("seq_count", 32'(o_count), 4);

    // Back-pressure: third code waits until the sink drains.
    send(3, 1'b0);
    send(1, 1'b0);
    cyc(1'b1, 2, 1'b0, 1'b0, acc);
    chk("full_ready", 32'(o_ready), 0);
    chk("full_held", 32'(acc), 0);
    cyc(1'b1, 2, 1'b0, 1'b0, acc);
    send(2, 1'b1);
    idle(4, 1'b1);

    // Simultaneous push and pop while holding one entry.
    send(2, 1'b0);
    cyc(1'b1, 0, 1'b1, 1'b0, acc);
    chk("pp_accept", 32'(acc), 1);
    cyc(1'b0, 0, 1'b0, 1'b0, acc);
    chk("pp_head", 32'(o_onehot), dec(0));
    chk("pp_valid", 32'(o_valid), 1);
    chk("pp_ready", 32'(o_ready), 1);
    idle(3, 1'b1);

    // Counter saturation and clear variants.
    cyc(1'b0, 0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 300; k++) send(1, 1'b1);
    idle(3, 1'b1);
    chk("sat_count", 32'(o_count), 255);
    chk("sat_accum", 32'(o_accum), dec(1));
    cyc(1'b0, 0, 1'b0, 1'b1, acc);
    cyc(1'b0, 0, 1'b0, 1'b0, acc);
    chk("clr_count", 32'(o_count), 0);
    chk("clr_accum", 32'(o_accum), 0);
    send(3, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, acc);
    cyc(1'b0, 0, 1'b1, 1'b1, acc);
    cyc(1'b0, 0, 1'b0, 1'b0, acc);
    chk("clrpop_count", 32'(o_count), 1);
    chk("clrpop_accum", 32'(o_accum), dec(3));
    idle(2, 1'b1);

    // Random traffic.
    for (int k = 0; k < 500; k++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), acc);
    end
    idle(4, 1'b1);

    // Asynchronous reset while full discards buffered codes.
    send(1, 1'b0);
    send(2, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, acc);
    chk("prerst_ready", 32'(o_ready), 0);
    chk("prerst_valid", 32'(o_valid), 1);
    #2 i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", 32'(o_valid), 0);
    chk("arst_ready", 32'(o_ready), 1);
    chk("arst_onehot", 32'(o_onehot), 0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    idle(5, 1'b1);
    chk("post_rst_valid", 32'(o_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
